wb_write_arbiter: RTL

- Write-back side of the register file: merges results from two producers into the register file's single write port.
- Drives WriteReg, WriteData and WriteEn.
- Channel A: single-cycle ALU results, one-entry holding register.
- Channel B: long-latency results (loads, mult/div), B_DEPTH FIFO.
- Arbitration is A-priority with a starvation guard for B. Writes to $zero are consumed but suppressed.

---
 rtl/wb_write_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb_write_arbiter.sv
// Register-file write-back arbiter: one-entry ALU holding register (A) and a
// B_DEPTH FIFO for long-latency results (B). Optional macro: WB_PENDING_MASK_EN.
module wb_write_arbiter #(
  parameter int B_DEPTH      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [4:0]                 a_reg,
  input  logic [31:0]                a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [4:0]                 b_reg,
  input  logic [31:0]                b_data,
  output logic [4:0]                 WriteReg,
  output logic [31:0]                WriteData,
  output logic                       WriteEn,
  output logic [$clog2(B_DEPTH):0]   b_count,
  output logic                       idle,
  output logic [31:0]                pending_mask
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(B_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SC_W   = $clog2(STARVE_LIMIT + 1);

  logic              a_vld_p0;
  logic [4:0]        a_reg_p0;
  logic [DATA_W-1:0] a_data_p0;

  logic [4:0]        b_reg_mem  [B_DEPTH];
  logic [DATA_W-1:0] b_data_mem [B_DEPTH];
  logic [PTR_W-1:0]  b_wr_ptr;
  logic [PTR_W-1:0]  b_rd_ptr;
  logic [SC_W-1:0]   starve_cnt;

  logic              b_nonempty;
  logic              b_force;
  logic              grant_a;
  logic              grant_b;
  logic              a_push;
  logic              b_push;
  logic [4:0]        b_head_reg;
  logic [4:0]        g_reg;
  logic [DATA_W-1:0] g_data;

  // B wins a contested cycle when starved, or when both target the same
  // nonzero register: the FIFO head is older, so it must land first.
  always_comb begin
    b_head_reg = b_reg_mem[b_rd_ptr];
    b_nonempty = (b_count != '0);
    b_force    = (starve_cnt == SC_W'(STARVE_LIMIT)) ||
                 ((a_reg_p0 == b_head_reg) && (a_reg_p0 != 5'd0));
    grant_b    = b_nonempty && (!a_vld_p0 || b_force);
    grant_a    = a_vld_p0 && !grant_b;
  end

  // Ready is held low during reset so the reset cycle never completes a handshake.
  assign a_ready = !reset && (!a_vld_p0 || grant_a);
  assign b_ready = !reset && ((b_count < CNT_W'(B_DEPTH)) || grant_b);
  assign a_push  = a_valid && a_ready;
  assign b_push  = b_valid && b_ready;

  always_comb begin
    g_reg  = a_reg_p0;
    g_data = a_data_p0;
    if (grant_b) begin
      g_reg  = b_head_reg;
      g_data = b_data_mem[b_rd_ptr];
    end
  end

  // Stage p0: buffer state (A holding register, B FIFO, starvation counter)
  always_ff @(posedge clk) begin
    if (reset) begin
      a_vld_p0   <= 1'b0;
      b_wr_ptr   <= '0;
      b_rd_ptr   <= '0;
      b_count    <= '0;
      starve_cnt <= '0;
    end else begin
      if (a_push)
        a_vld_p0 <= 1'b1;
      else if (grant_a)
        a_vld_p0 <= 1'b0;

      if (b_push)
        b_wr_ptr <= b_wr_ptr + 1'b1;
      if (grant_b)
        b_rd_ptr <= b_rd_ptr + 1'b1;

      case ({b_push, grant_b})
        2'b10:   b_count <= b_count + 1'b1;
        2'b01:   b_count <= b_count - 1'b1;
        default: b_count <= b_count;
      endcase

      if (grant_b)
        starve_cnt <= '0;
      else if (b_nonempty && (starve_cnt != SC_W'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (a_push) begin
      a_reg_p0  <= a_reg;
      a_data_p0 <= a_data;
    end
    if (b_push) begin
      b_reg_mem[b_wr_ptr]  <= b_reg;
      b_data_mem[b_wr_ptr] <= b_data;
    end
  end

  // Stage p1: register-file write port; $zero entries are consumed silently
  always_ff @(posedge clk) begin
    if (reset) begin
      WriteEn   <= 1'b0;
      WriteReg  <= 5'd0;
      WriteData <= '0;
    end else begin
      WriteEn <= (grant_a || grant_b) && (g_reg != 5'd0);
      if (grant_a || grant_b) begin
        WriteReg  <= g_reg;
        WriteData <= g_data;
      end
    end
  end

  assign idle = !a_vld_p0 && (b_count == '0) && !WriteEn;

`ifdef WB_PENDING_MASK_EN
  logic [PTR_W-1:0] pm_idx;

  always_comb begin
    pending_mask = 32'h0;
    pm_idx       = b_rd_ptr;
    if (a_vld_p0)
      pending_mask[a_reg_p0] = 1'b1;
    for (int k = 0; k < B_DEPTH; k++) begin
      pm_idx = b_rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < b_count)
        pending_mask[b_reg_mem[pm_idx]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end
`else
  assign pending_mask = 32'h0;
`endif

endmodule
